// File: rtl/sequence_player_if.sv
// Sequence-memory read port: address/strobe out, data back one cycle after the strobe.
interface sequence_player_if;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rdata;

  modport master (output mem_addr, mem_rd_en, input mem_rdata);
  modport slave  (input mem_addr, mem_rd_en, output mem_rdata);
endinterface

// File: rtl/sequence_player.sv
// Plays a stored sequence of 64-bit words, each held step_cycles clocks, for N passes or forever.
// Optional SEQ_HOLD_LAST_EN: keep the last played word on seq_data after done/stop.
module sequence_player (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [15:0]             seq_len,
  input  logic [31:0]             step_cycles,
  input  logic [15:0]             repetitions,
  sequence_player_if.master       mem,
  output logic [63:0]             seq_data,
  output logic                    seq_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [15:0]             step_index,
  output logic [15:0]             rep_count
);

`ifdef SEQ_HOLD_LAST_EN
  localparam bit HOLD_LAST = 1'b1;
`else
  localparam bit HOLD_LAST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  state_t      state;
  logic [15:0] len_q, reps_q;
  logic [31:0] step_q, hold_cnt;
  logic [63:0] word_q;
  logic        load_q;

  logic [15:0] nxt_idx, rep_inc;
  logic        hold_end, last_word;

  assign nxt_idx   = (step_index == len_q - 16'd1) ? 16'd0 : step_index + 16'd1;
  assign rep_inc   = (rep_count == 16'hFFFF) ? rep_count : rep_count + 16'd1;
  assign hold_end  = (hold_cnt == step_q - 32'd1);
  assign last_word = (reps_q != 16'd0) && (rep_count == reps_q - 16'd1) &&
                     (step_index == len_q - 16'd1);

  // Memory returns data in the cycle after the strobe; that cycle shows it straight through
  // so that step_cycles=1 plays a new word every clock without gaps.
  assign seq_data = load_q ? mem.mem_rdata : word_q;
  assign busy     = (state != IDLE);

  always_comb begin
    mem.mem_rd_en = 1'b0;
    mem.mem_addr  = 16'd0;
    if (state == FETCH) begin
      mem.mem_rd_en = !stop;
    end else if (state == PLAY) begin
      mem.mem_rd_en = hold_end && !last_word && !stop;
      mem.mem_addr  = nxt_idx;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      len_q      <= '0;
      reps_q     <= '0;
      step_q     <= '0;
      hold_cnt   <= '0;
      word_q     <= '0;
      load_q     <= 1'b0;
      seq_valid  <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      step_index <= '0;
      rep_count  <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      load_q  <= 1'b0;
      if (load_q) word_q <= mem.mem_rdata;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (seq_len != 16'd0 && step_cycles != 32'd0) begin
              len_q      <= seq_len;
              step_q     <= step_cycles;
              reps_q     <= repetitions;
              rep_count  <= '0;
              step_index <= '0;
              hold_cnt   <= '0;
              state      <= FETCH;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            state      <= PLAY;
            load_q     <= 1'b1;
            seq_valid  <= 1'b1;
            step_index <= '0;
            hold_cnt   <= '0;
          end
        end
        PLAY: begin
          if (stop || (hold_end && last_word)) begin
            state     <= IDLE;
            seq_valid <= 1'b0;
            word_q    <= HOLD_LAST ? seq_data : 64'h0;
            if (!stop) begin
              done      <= 1'b1;
              rep_count <= rep_inc;
            end
          end else if (hold_end) begin
            load_q     <= 1'b1;
            step_index <= nxt_idx;
            hold_cnt   <= '0;
            if (nxt_idx == 16'd0) rep_count <= rep_inc;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player: stimulus pushes expected words/events, a negedge monitor checks them.
module tb_sequence_player;

`ifdef SEQ_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0, aresetn = 1'b0, start = 1'b0, stop = 1'b0;
  logic [15:0] seq_len = '0, repetitions = '0;
  logic [31:0] step_cycles = '0;
  logic [63:0] seq_data;
  logic        seq_valid, busy, done, cfg_err;
  logic [15:0] step_index, rep_count;

  sequence_player_if mif();

  sequence_player dut (
    .clk(clk), .aresetn(aresetn), .start(start), .stop(stop),
    .seq_len(seq_len), .step_cycles(step_cycles), .repetitions(repetitions),
    .mem(mif.master),
    .seq_data(seq_data), .seq_valid(seq_valid), .busy(busy), .done(done),
    .cfg_err(cfg_err), .step_index(step_index), .rep_count(rep_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] memword(int i);
    return {16'hC0DE, 16'(i), 16'hBEEF, 16'(i)};
  endfunction

  logic [63:0] mem [0:7];
  always @(posedge clk) if (mif.mem_rd_en) mif.mem_rdata <= mem[mif.mem_addr[2:0]];

  typedef struct {int cyc; logic [63:0] data; logic [15:0] idx; logic [15:0] rep;} exp_t;
  typedef struct {int cyc; logic [1:0] kind;} ev_t;  // kind = {cfg_err, done}
  exp_t exp_q[$];
  ev_t  ev_q[$];
  exp_t me;
  ev_t  mv;
  int total = 0, bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: one expected record per played cycle, one per done/cfg_err pulse.
  initial forever begin
    @(negedge clk);
    if (aresetn) begin
      if (seq_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got %h at cyc %0d want none", seq_data, cyc);
        end else begin
          me = exp_q.pop_front();
          chk("word_cyc", 64'(cyc), 64'(me.cyc));
          chk("word_data", seq_data, me.data);
          chk("word_idx", 64'(step_index), 64'(me.idx));
          chk("word_rep", 64'(rep_count), 64'(me.rep));
        end
      end
      if (done || cfg_err) begin
        if (ev_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pulse: got done=%b cfg_err=%b at cyc %0d want none", done, cfg_err, cyc);
        end else begin
          mv = ev_q.pop_front();
          chk("ev_cyc", 64'(cyc), 64'(mv.cyc));
          chk("ev_kind", 64'({cfg_err, done}), 64'(mv.kind));
        end
      end
    end
  end

  // Called just after a negedge; k is the cycle count after the edge that samples start.
  task automatic do_start(int len, int step, int reps, output int k);
    ev_t v;
    seq_len = 16'(len); step_cycles = 32'(step); repetitions = 16'(reps);
    start = 1'b1;
    k = cyc + 1;
    if (len == 0 || step == 0) begin
      v.cyc = k; v.kind = 2'b10; ev_q.push_back(v);
    end
    @(negedge clk);
    start = 1'b0;
    seq_len = 16'd7; step_cycles = 32'd3; repetitions = 16'd9;
  endtask

  task automatic push_play(int k, int len, int step, int reps, int ncyc);
    exp_t e;
    ev_t  v;
    int lim, w;
    lim = ncyc;
    if (reps != 0 && len * reps * step < lim) lim = len * reps * step;
    for (int t = 0; t < lim; t++) begin
      w = t / step;
      e.cyc  = k + 1 + t;
      e.idx  = 16'(w % len);
      e.data = memword(w % len);
      e.rep  = (w / len > 65535) ? 16'hFFFF : 16'(w / len);
      exp_q.push_back(e);
    end
    if (reps != 0 && ncyc >= len * reps * step) begin
      v.cyc = k + 1 + lim; v.kind = 2'b01; ev_q.push_back(v);
    end
  endtask

  task automatic wait_until(int c);
    int n;
    n = 0;
    while (cyc < c && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != c) begin
      total++; bad++;
      $display("FAIL wait: got cyc %0d want %0d", cyc, c);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_data"}, seq_data, 64'h0);
    chk({tag, "_valid"}, 64'(seq_valid), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_done"}, 64'(done), 64'h0);
    chk({tag, "_cfgerr"}, 64'(cfg_err), 64'h0);
    chk({tag, "_idx"}, 64'(step_index), 64'h0);
    chk({tag, "_rep"}, 64'(rep_count), 64'h0);
    chk({tag, "_rden"}, 64'(mif.mem_rd_en), 64'h0);
    chk({tag, "_addr"}, 64'(mif.mem_addr), 64'h0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 8; i++) mem[i] = memword(i);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    aresetn = 1'b1;
    @(negedge clk);

    // A,B,C x2 at 4 cycles each; start held high during playback must not restart
    do_start(3, 4, 2, k);
    push_play(k, 3, 4, 2, 1000);
    start = 1'b1;
    wait_until(k + 20);
    start = 1'b0;
    wait_until(k + 25);
    chk("a_busy", 64'(busy), 64'h0);
    chk("a_valid", 64'(seq_valid), 64'h0);
    chk("a_rep", 64'(rep_count), 64'd2);
    chk("a_data", seq_data, HOLD ? memword(2) : 64'h0);

    // start+stop together in IDLE with a valid config: nothing happens
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", 64'(busy), 64'h0);
    @(negedge clk);
    chk("ss_busy2", 64'(busy), 64'h0);

    // step=1 forever, 20 words, then stop
    do_start(4, 1, 0, k);
    push_play(k, 4, 1, 0, 20);
    wait_until(k + 20);
    stop = 1'b1;
    #1;
    chk("b_stop_rd_gate", 64'(mif.mem_rd_en), 64'h0);
    @(negedge clk);
    stop = 1'b0;
    chk("b_busy", 64'(busy), 64'h0);
    chk("b_valid", 64'(seq_valid), 64'h0);
    chk("b_rden", 64'(mif.mem_rd_en), 64'h0);
    chk("b_data", seq_data, HOLD ? memword(3) : 64'h0);

    // stop mid-hold of word 2
    do_start(5, 10, 0, k);
    push_play(k, 5, 10, 0, 25);
    wait_until(k + 25);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("c_busy", 64'(busy), 64'h0);
    chk("c_valid", 64'(seq_valid), 64'h0);
    chk("c_rden", 64'(mif.mem_rd_en), 64'h0);
    chk("c_data", seq_data, HOLD ? memword(2) : 64'h0);

    // bad configurations
    do_start(3, 0, 1, k);
    chk("d_busy", 64'(busy), 64'h0);
    chk("d_rden", 64'(mif.mem_rd_en), 64'h0);
    @(negedge clk);
    chk("d_busy2", 64'(busy), 64'h0);
    do_start(0, 5, 1, k);
    chk("d_len0_busy", 64'(busy), 64'h0);
    @(negedge clk);

    // single-word sequence rereads address 0
    do_start(1, 2, 3, k);
    push_play(k, 1, 2, 3, 1000);
    wait_until(k + 2);
    chk("e_rden", 64'(mif.mem_rd_en), 64'h1);
    chk("e_addr", 64'(mif.mem_addr), 64'h0);
    wait_until(k + 8);
    chk("e_rep", 64'(rep_count), 64'd3);

    // async reset during word 1, then restart from word 0
    do_start(3, 4, 0, k);
    push_play(k, 3, 4, 0, 6);
    wait_until(k + 6);
    #1 aresetn = 1'b0;
    #1 chk_zero("areset");
    #1 aresetn = 1'b1;
    @(negedge clk);
    do_start(3, 2, 1, k);
    push_play(k, 3, 2, 1, 1000);
    wait_until(k + 8);
    chk("f_rep", 64'(rep_count), 64'd1);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'h0);
    chk("ev_q_empty", 64'(ev_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 The block SHALL have a single clock domain: clk input 1 bit (all logic on rising edge); reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock.
REQ-003 aresetn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle request to begin playback.
REQ-005 stop  input  1  single-cycle request to abort playback.
REQ-006 seq_len  input  16  number of 64-bit sequence words (1..65535).
REQ-007 step_cycles  input  32  clock cycles each word is held (>=1).
REQ-008 repetitions  input  16  passes over the sequence; 0 = loop forever.
REQ-009 mem_addr  output  16  word address into the sequence memory.
REQ-010 mem_rd_en  output  1  read strobe; mem_rdata valid exactly 1 cycle later.
REQ-011 mem_rdata  input  64  sequence word from memory.
REQ-012 seq_data  output  64  current word, feeds the DAC/PDM slice decoder.
REQ-013 seq_valid  output  1  seq_data holds a word being played.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse on natural completion of all repetitions.
REQ-016 cfg_err  output  1  one-cycle pulse when start is rejected for bad configuration.
REQ-017 step_index  output  16  index of the word currently in seq_data.
REQ-018 rep_count  output  16  completed full passes since start.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, PLAY.
REQ-020 IDLE + start=1 + stop=0 + seq_len!=0 + step_cycles!=0 -> latch seq_len, step_cycles, repetitions; go to FETCH; clear rep_count.
REQ-021 IDLE + start=1 with seq_len=0 or step_cycles=0 -> stay IDLE, cfg_err=1 for the next cycle.
REQ-022 Configuration inputs changing after the start cycle SHALL have no effect until the next accepted start.
REQ-023 FETCH (one cycle): mem_rd_en=1, mem_addr=0; next cycle -> PLAY, seq_data=mem_rdata, step_index=0, seq_valid=1, hold counter=0.
REQ-024 First word SHALL appear on seq_data exactly 2 cycles after the accepted start cycle.
REQ-025 PLAY: hold counter increments each cycle; each word is held exactly step_cycles cycles, including step_cycles=1 (new word every cycle, no gaps).
REQ-026 mem_rd_en and mem_addr SHALL be combinational from registered state: in PLAY, mem_rd_en=1 when hold counter = step_cycles-1 and another word follows; mem_addr = next index.
REQ-027 On the cycle after a read, seq_data <= mem_rdata, step_index <= next index, hold counter <= 0.
REQ-028 Wrap: next index after seq_len-1 is 0; rep_count increments in the same cycle step_index returns to 0.
REQ-029 repetitions=0: playback SHALL wrap indefinitely; rep_count saturates at 16'hFFFF.
REQ-030 repetitions=N!=0: after the final word of pass N completes its hold, no read is issued; next cycle -> IDLE, done=1 for one cycle, rep_count=N, seq_valid=0.
REQ-031 stop=1 in FETCH or PLAY -> IDLE on the next cycle, seq_valid=0, no done pulse, no further read issued that cycle.
REQ-032 start while busy SHALL be ignored; start and stop in the same IDLE cycle: stop wins, no start, no cfg_err.
REQ-033 seq_len=1 SHALL replay word 0 every step_cycles, rereading address 0 each time.

Reset
REQ-034 aresetn=0 SHALL immediately force state IDLE and seq_data=0, seq_valid=0, busy=0, done=0, cfg_err=0, step_index=0, rep_count=0, mem_rd_en=0, mem_addr=0, regardless of state.
REQ-035 After reset deassertion the block SHALL require a new start; latched configuration SHALL be cleared.

Configuration
REQ-036 Macro SEQ_HOLD_LAST_EN defined: on entering IDLE via done or stop, seq_data SHALL keep the last played word (seq_valid still 0).
REQ-037 SEQ_HOLD_LAST_EN undefined: on entering IDLE via done or stop, seq_data SHALL be cleared to 64'h0 the same cycle seq_valid falls.

Verification
REQ-038 seq_len=3, step_cycles=4, repetitions=2, memory words A,B,C -> seq_data A,B,C,A,B,C each 4 cycles from start+2, done pulse at start+26, rep_count=2.
REQ-039 seq_len=4, step_cycles=1, repetitions=0, run 20 cycles -> word changes every cycle, wraps 3->0, rep_count=4 after 16 played words, no done.
REQ-040 stop asserted mid-hold of word 2 (seq_len=5, step_cycles=10) -> next cycle busy=0, seq_valid=0, no done, no mem_rd_en; seq_data=word2 with macro, 0 without.
REQ-041 start with step_cycles=0 -> cfg_err one cycle, busy stays 0, no mem_rd_en.
REQ-042 aresetn pulsed low during PLAY of word 1 -> all outputs zero asynchronously; subsequent start replays from word 0 with rep_count=0.
REQ-043 start asserted every cycle during playback and start+stop together in IDLE -> no restart, no cfg_err, playback timing unchanged.
